// File: rtl/obi_prn_fetcher.sv
// obi_prn_fetcher: OBI manager fetching PRNs (trigger write, data read) into a valid/ready FIFO
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   start_i, count_i              job start (sampled in IDLE) and number of PRNs to fetch
//   busy_o, done_o, error_o       job in progress, one-cycle end pulse, sticky abort flag
//   req_o .. aid_o, gnt_i         OBI request channel
//   rvalid_i .. err_i             OBI response channel
//   prn_valid_o, prn_data_o,
//   prn_ready_i                   PRN stream out of the FIFO
module obi_prn_fetcher #(
    parameter int unsigned                ADDR_WIDTH_OBI = 32,
    parameter int unsigned                DATA_WIDTH_OBI = 32,
    parameter int unsigned                ID_WIDTH_OBI   = 4,
    parameter logic [ADDR_WIDTH_OBI-1:0]  BASE_ADDR      = 32'h2000_1000,
    parameter int unsigned                FIFO_DEPTH     = 4,
    parameter int unsigned                CNT_WIDTH      = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    input  logic [CNT_WIDTH-1:0]      count_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      error_o,
    output logic                      req_o,
    output logic                      we_o,
    output logic [3:0]                be_o,
    output logic [ADDR_WIDTH_OBI-1:0] addr_o,
    output logic [DATA_WIDTH_OBI-1:0] wdata_o,
    output logic [ID_WIDTH_OBI-1:0]   aid_o,
    input  logic                      gnt_i,
    input  logic                      rvalid_i,
    input  logic [DATA_WIDTH_OBI-1:0] rdata_i,
    input  logic [ID_WIDTH_OBI-1:0]   rid_i,
    input  logic                      err_i,
    output logic                      prn_valid_o,
    output logic [DATA_WIDTH_OBI-1:0] prn_data_o,
    input  logic                      prn_ready_i
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP, DONE} state_e;

    state_e                    state_q, state_d;
    logic [CNT_WIDTH-1:0]      remaining_q, remaining_d;
    logic                      error_q, error_d;
    logic [ID_WIDTH_OBI-1:0]   id_q, rsp_id_q;
    logic [DATA_WIDTH_OBI-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]          wptr_q, rptr_q;
    logic [LVL_W-1:0]          level_q;
    logic                      fifo_free, grant, rsp_ok, push, pop;

    assign fifo_free = level_q < LVL_W'(FIFO_DEPTH);
    assign grant     = req_o && gnt_i;
    // rsp_id_q holds the ID of the single outstanding transaction
    assign rsp_ok    = rvalid_i && !err_i && rid_i == rsp_id_q;
    assign push      = state_q == RD_RSP && rsp_ok;
    assign pop       = level_q != '0 && prn_ready_i;

    assign busy_o      = state_q != IDLE;
    assign done_o      = state_q == DONE;
    assign error_o     = error_q;
    assign be_o        = 4'hF;
    assign wdata_o     = '0;
    assign aid_o       = id_q;
    assign prn_valid_o = level_q != '0;
    assign prn_data_o  = prn_valid_o ? mem_q[rptr_q] : '0;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        error_d     = error_q;
        req_o       = 1'b0;
        we_o        = 1'b0;
        addr_o      = '0;
        case (state_q)
            IDLE: if (start_i) begin
                error_d     = 1'b0;
                remaining_d = count_i;
                state_d     = count_i != '0 ? WR_REQ : DONE;
            end
            WR_REQ: begin
                req_o   = 1'b1;
                we_o    = 1'b1;
                addr_o  = BASE_ADDR;
                state_d = gnt_i ? WR_RSP : WR_REQ;
            end
            WR_RSP: if (rvalid_i) begin
                error_d = !rsp_ok;
                state_d = rsp_ok ? RD_REQ : DONE;
            end
            RD_REQ: begin
                // never issue a read whose data could not be stored
                req_o   = fifo_free;
                addr_o  = BASE_ADDR + ADDR_WIDTH_OBI'(4);
                state_d = grant ? RD_RSP : RD_REQ;
            end
            RD_RSP: if (rvalid_i) begin
                error_d     = !rsp_ok;
                remaining_d = rsp_ok ? remaining_q - CNT_WIDTH'(1) : remaining_q;
                state_d     = rsp_ok && remaining_q != CNT_WIDTH'(1) ? WR_REQ : DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            error_q     <= 1'b0;
            id_q        <= '0;
            rsp_id_q    <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            level_q     <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            error_q     <= error_d;
            if (grant) begin
                id_q     <= id_q + ID_WIDTH_OBI'(1);
                rsp_id_q <= id_q;
            end
            if (push) wptr_q <= wptr_q + PTR_W'(1);
            if (pop) rptr_q <= rptr_q + PTR_W'(1);
            level_q <= level_q + LVL_W'(push) - LVL_W'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= rdata_i;
    end
endmodule

// File: tb/tb_obi_prn_fetcher.sv
// tb_obi_prn_fetcher: table-driven and randomized bench with an OBI responder and stream scoreboard
module tb_obi_prn_fetcher;
    localparam int IDW   = 3;
    localparam int DEPTH = 4;
    localparam int LIMIT = 600;
    localparam logic [31:0] BASE = 32'h2000_1000;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            start_i = 1'b0;
    logic [15:0]     count_i = '0;
    logic            busy_o, done_o, error_o, req_o, we_o;
    logic [3:0]      be_o;
    logic [31:0]     addr_o, wdata_o;
    logic [IDW-1:0]  aid_o;
    logic            gnt_i = 1'b0, rvalid_i = 1'b0, err_i = 1'b0;
    logic [31:0]     rdata_i = '0;
    logic [IDW-1:0]  rid_i = '0;
    logic            prn_valid_o;
    logic [31:0]     prn_data_o;
    logic            prn_ready_i = 1'b0;

    obi_prn_fetcher #(.ID_WIDTH_OBI(IDW), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .count_i(count_i),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
        .req_o(req_o), .we_o(we_o), .be_o(be_o), .addr_o(addr_o), .wdata_o(wdata_o),
        .aid_o(aid_o), .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i),
        .rid_i(rid_i), .err_i(err_i), .prn_valid_o(prn_valid_o),
        .prn_data_o(prn_data_o), .prn_ready_i(prn_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int c, gd, rd, rm, fa, fk;
        bit drain, stray;
        int exp_err, exp_prn;
    } vec_t;

    int checks = 0, errors = 0;
    logic [31:0] exp_q[$];
    int lvl = 0;
    bit pend = 0, pend_rd = 0;
    int pend_wait = 0, pend_idx = 0;
    logic [IDW-1:0] pend_id = '0;
    int gwait = 0, txn = 0, reads_ok = 0, id_model = 0, cur_total = 0;
    int cfg_gd = 0, cfg_rd = 0, cfg_rmode = 0, cfg_fail = 0, cfg_kind = 0;
    bit cfg_stray = 0;
    int full_ticks = 0, done_cnt = 0;
    bit prev_req = 0, prev_gnt = 0, prev_we = 0;
    logic [31:0] prev_addr = '0;
    logic [IDW-1:0] prev_aid = '0;

    task automatic expect_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle: check outputs at the negedge, then drive consumer and responder for the next edge.
    task automatic tick();
        @(negedge clk_i);
        expect_eq("prn_valid", prn_valid_o, lvl != 0);
        if (lvl >= DEPTH && !we_o) expect_eq("rd_req_when_full", req_o, 0);
        if (req_o && prev_req && !prev_gnt) begin
            expect_eq("hold_addr", addr_o, prev_addr);
            expect_eq("hold_we", we_o, prev_we);
            expect_eq("hold_aid", aid_o, prev_aid);
        end
        prev_req = req_o; prev_addr = addr_o; prev_we = we_o; prev_aid = aid_o;
        if (done_o) done_cnt++;
        case (cfg_rmode)
            0: prn_ready_i = 1'b1;
            1: prn_ready_i = 1'($urandom_range(0, 1));
            2: begin
                if (lvl >= DEPTH) full_ticks++;
                prn_ready_i = full_ticks > 10;
            end
            default: prn_ready_i = 1'b0;
        endcase
        if (prn_valid_o && prn_ready_i && lvl > 0) begin
            expect_eq("stream_data", prn_data_o, exp_q.pop_front());
            lvl--;
        end
        gnt_i = 0; rvalid_i = 0; err_i = 0; rid_i = '0; rdata_i = '0;
        if (pend) begin
            if (pend_wait == 0) begin
                rvalid_i = 1; rid_i = pend_id; rdata_i = $urandom;
                if (pend_idx == cfg_fail) begin
                    if (cfg_kind == 0) err_i = 1;
                    else rid_i = pend_id ^ IDW'(1);
                end else if (pend_rd) begin
                    exp_q.push_back(rdata_i);
                    lvl++;
                    reads_ok++;
                end
                pend = 0;
            end else pend_wait--;
        end else if (req_o) begin
            if (gwait == 0) begin
                gnt_i = 1;
                txn++;
                expect_eq("extra_req", 64'(txn > cur_total), 0);
                expect_eq("we", we_o, txn % 2);
                expect_eq("addr", addr_o, (txn % 2) ? BASE : BASE + 32'd4);
                expect_eq("aid", aid_o, id_model);
                expect_eq("be", be_o, 4'hF);
                expect_eq("wdata", wdata_o, 0);
                pend = 1; pend_rd = (txn % 2) == 0; pend_idx = txn; pend_id = IDW'(id_model);
                pend_wait = cfg_rd; gwait = cfg_gd;
                id_model = (id_model + 1) % (1 << IDW);
            end else gwait--;
        end else if (cfg_stray && $urandom_range(0, 3) == 0) begin
            rvalid_i = 1; rdata_i = $urandom; rid_i = IDW'($urandom);
        end
        prev_gnt = gnt_i;
    endtask

    task automatic reset_checks(input string tag);
        expect_eq({tag, "_busy"}, busy_o, 0);
        expect_eq({tag, "_done"}, done_o, 0);
        expect_eq({tag, "_error"}, error_o, 0);
        expect_eq({tag, "_req"}, req_o, 0);
        expect_eq({tag, "_we"}, we_o, 0);
        expect_eq({tag, "_addr"}, addr_o, 0);
        expect_eq({tag, "_aid"}, aid_o, 0);
        expect_eq({tag, "_prn_valid"}, prn_valid_o, 0);
        expect_eq({tag, "_prn_data"}, prn_data_o, 0);
    endtask

    task automatic clear_model();
        pend = 0; lvl = 0; exp_q.delete(); id_model = 0;
        prev_req = 0; prev_gnt = 0; gwait = cfg_gd;
        gnt_i = 0; rvalid_i = 0; err_i = 0;
    endtask

    task automatic run_job(input vec_t v);
        int n;
        cfg_gd = v.gd; cfg_rd = v.rd; cfg_rmode = v.rm; cfg_fail = v.fa; cfg_kind = v.fk;
        cfg_stray = v.stray;
        gwait = v.gd; txn = 0; reads_ok = 0; full_ticks = 0; done_cnt = 0;
        cur_total = (v.fa != 0 && v.fa <= 2 * v.c) ? v.fa : 2 * v.c;
        expect_eq("idle_before_start", busy_o, 0);
        start_i = 1; count_i = 16'(v.c);
        tick();
        start_i = 0; n = 1;
        expect_eq("busy_after_start", busy_o, 1);
        expect_eq("error_cleared", error_o, 0);
        while (!done_o && n < LIMIT) begin
            if (n == 2 && busy_o) begin
                start_i = 1; count_i = 16'd7;
            end
            tick();
            start_i = 0; n++;
        end
        expect_eq("done_reached", done_o, 1);
        if (v.gd == 0 && v.rd == 0 && v.rm == 0 && v.fa == 0) expect_eq("latency", n, 4 * v.c + 1);
        expect_eq("error_o", error_o, v.exp_err);
        expect_eq("prns_fetched", reads_ok, v.exp_prn);
        expect_eq("txns", txn, cur_total);
        tick();
        expect_eq("done_pulses", done_cnt, 1);
        expect_eq("done_low", done_o, 0);
        expect_eq("idle_after", busy_o, 0);
        expect_eq("error_sticky", error_o, v.exp_err);
        if (v.drain) begin
            cfg_rmode = 0; n = 0;
            while (lvl != 0 && n < 50) begin
                tick(); n++;
            end
            tick();
            expect_eq("drained", prn_valid_o, 0);
        end
    endtask

    initial begin
        vec_t vecs[9];
        vec_t r;
        int n;
        //           c gd rd rm fa fk dr st err prn
        vecs[0] = '{3, 0, 0, 0, 0, 0, 1, 0, 0, 3};
        vecs[1] = '{6, 0, 0, 2, 0, 0, 1, 0, 0, 6};
        vecs[2] = '{2, 3, 0, 0, 0, 0, 1, 0, 0, 2};
        vecs[3] = '{4, 0, 1, 0, 4, 0, 1, 0, 1, 1};
        vecs[4] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        vecs[5] = '{3, 1, 2, 1, 1, 1, 1, 0, 1, 0};
        vecs[6] = '{2, 0, 0, 3, 0, 0, 0, 0, 0, 2};
        vecs[7] = '{5, 0, 0, 1, 6, 1, 1, 0, 1, 2};
        vecs[8] = '{3, 0, 3, 0, 0, 0, 1, 1, 0, 3};

        repeat (3) @(negedge clk_i);
        reset_checks("reset");
        rst_ni = 1;
        tick();

        foreach (vecs[i]) run_job(vecs[i]);

        // reset while a read response is outstanding
        cfg_gd = 0; cfg_rd = 2; cfg_rmode = 0; cfg_fail = 0; cfg_stray = 0;
        gwait = 0; txn = 0; cur_total = 10; done_cnt = 0;
        start_i = 1; count_i = 16'd5;
        tick();
        start_i = 0; n = 0;
        while (!(pend && pend_rd) && n < 100) begin
            tick(); n++;
        end
        expect_eq("reached_rd_rsp", pend && pend_rd, 1);
        rst_ni = 0;
        clear_model();
        #1;
        reset_checks("midjob_reset");
        done_cnt = 0;
        repeat (2) tick();
        expect_eq("no_done_in_reset", done_cnt, 0);
        rst_ni = 1;
        tick();
        run_job('{2, 0, 0, 0, 0, 0, 1, 0, 0, 2});

        for (int k = 0; k < 30; k++) begin
            r.c = $urandom_range(0, 9);
            r.gd = $urandom_range(0, 3);
            r.rd = $urandom_range(0, 3);
            r.rm = 1;
            r.fa = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2 * r.c + 2) : 0;
            r.fk = $urandom_range(0, 1);
            r.drain = 1'($urandom_range(0, 1));
            r.stray = 1;
            r.exp_err = (r.fa != 0 && r.fa <= 2 * r.c) ? 1 : 0;
            r.exp_prn = r.exp_err != 0 ? (r.fa - 1) / 2 : r.c;
            run_job(r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
